// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable multi-channel clock divider.
// Optional feature macro: CLKDIV_PROG_SYNC_EN (adds the sync input).
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MAX_CH       = 16;
  localparam int unsigned CLKDIV_CH_W         = 4;
  localparam int unsigned CLKDIV_WIDTH_DEF    = 16;
  localparam int unsigned CLKDIV_DIV_INIT_DEF = 1;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_chan.sv
// One divider channel: shadow/active divisor, period counter, tick and square wave.
// Optional feature macro: CLKDIV_PROG_SYNC_EN (adds the sync input).
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH    = CLKDIV_WIDTH_DEF,
  parameter int unsigned DIV_INIT = CLKDIV_DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLKDIV_PROG_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             tick,
  output logic             div_out
);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] sdiv_q, sdiv_d;
  logic [WIDTH-1:0] adiv_q, adiv_d;
  logic             tick_q, tick_d;
  logic             div_q,  div_d;

  // Next-state: shadow write, period counting, and terminal-cycle reload with write bypass.
  always_comb begin
    sdiv_d = sdiv_q;
    cnt_d  = cnt_q;
    adiv_d = adiv_q;
    tick_d = 1'b0;
    div_d  = div_q;

    if (wr) begin
      sdiv_d = wr_data;
    end

    if (!en) begin
      cnt_d  = '0;
      div_d  = 1'b0;
      adiv_d = sdiv_d;
    end else if (cnt_q == adiv_q) begin
      cnt_d  = '0;
      adiv_d = sdiv_d;
      tick_d = 1'b1;
      div_d  = ~div_q;
    end else begin
      cnt_d  = cnt_q + WIDTH'(1);
    end

`ifdef CLKDIV_PROG_SYNC_EN
    // Phase alignment wins over normal counting.
    if (sync) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      div_d  = 1'b0;
      adiv_d = sdiv_d;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sdiv_q <= WIDTH'(DIV_INIT);
      adiv_q <= WIDTH'(DIV_INIT);
      tick_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sdiv_q <= sdiv_d;
      adiv_q <= adiv_d;
      tick_q <= tick_d;
      div_q  <= div_d;
    end
  end

  assign tick    = tick_q;
  assign div_out = div_q;

endmodule : clkdiv_chan

// File: rtl/clkdiv_prog.sv
// Programmable multi-channel clock divider: free-running counter, divisor write decode, channels.
// Optional feature macro: CLKDIV_PROG_SYNC_EN (adds the sync input aligning all channel phases).
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH    = CLKDIV_WIDTH_DEF,
  parameter int unsigned CH       = 4,
  parameter int unsigned DIV_INIT = CLKDIV_DIV_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef CLKDIV_PROG_SYNC_EN
  input  logic                   sync,
`endif
  input  logic [CH-1:0]          en,
  input  logic                   wr_en,
  input  logic [CLKDIV_CH_W-1:0] wr_ch,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_err,
  output logic [WIDTH-1:0]       free_cnt,
  output logic [CH-1:0]          tick,
  output logic [CH-1:0]          div_out
);

  localparam int unsigned CHW = CLKDIV_CH_W;
  // One extra bit so CH = 16 compares correctly against a 4-bit channel index.
  localparam logic [CHW:0] CH_LIM = (CHW+1)'(CH);

  logic [WIDTH-1:0] free_cnt_q, free_cnt_d;
  logic             wr_err_q,   wr_err_d;
  logic [CH-1:0]    wr_sel_c;

  // Free-running counter, out-of-range write flag and per-channel write select.
  always_comb begin
    free_cnt_d = free_cnt_q + WIDTH'(1);
    wr_err_d   = wr_en && ({1'b0, wr_ch} >= CH_LIM);
    wr_sel_c   = '0;
    for (int i = 0; i < int'(CH); i++) begin
      wr_sel_c[i] = wr_en && (wr_ch == CHW'(i));
    end
  end

  // Top-level registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      free_cnt_q <= free_cnt_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign free_cnt = free_cnt_q;
  assign wr_err   = wr_err_q;

  for (genvar g = 0; g < int'(CH); g++) begin : g_chan
    clkdiv_chan #(
      .WIDTH    (WIDTH),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
`ifdef CLKDIV_PROG_SYNC_EN
      .sync    (sync),
`endif
      .en      (en[g]),
      .wr      (wr_sel_c[g]),
      .wr_data (wr_data),
      .tick    (tick[g]),
      .div_out (div_out[g])
    );
  end

endmodule : clkdiv_prog
